// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station.
// Op encodings, index widths, default sizes and boolean constants.
package alu_rs_pkg;

    localparam int RS_SIZE_DEF     = 16;
    localparam int ROB_INDEX_RANGE = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [5:0] op_t;

    localparam op_t OP_LUI   = 6'd1;
    localparam op_t OP_AUIPC = 6'd2;
    localparam op_t OP_JAL   = 6'd3;
    localparam op_t OP_JALR  = 6'd4;
    localparam op_t OP_BEQ   = 6'd5;
    localparam op_t OP_BNE   = 6'd6;
    localparam op_t OP_BLT   = 6'd7;
    localparam op_t OP_BGE   = 6'd8;
    localparam op_t OP_BLTU  = 6'd9;
    localparam op_t OP_BGEU  = 6'd10;
    localparam op_t OP_ADDI  = 6'd19;
    localparam op_t OP_SLTI  = 6'd20;
    localparam op_t OP_SLTIU = 6'd21;
    localparam op_t OP_XORI  = 6'd22;
    localparam op_t OP_ORI   = 6'd23;
    localparam op_t OP_ANDI  = 6'd24;
    localparam op_t OP_SLLI  = 6'd25;
    localparam op_t OP_SRLI  = 6'd26;
    localparam op_t OP_SRAI  = 6'd27;
    localparam op_t OP_ADD   = 6'd28;
    localparam op_t OP_SUB   = 6'd29;
    localparam op_t OP_SLL   = 6'd30;
    localparam op_t OP_SLT   = 6'd31;
    localparam op_t OP_SLTU  = 6'd32;
    localparam op_t OP_XOR   = 6'd33;
    localparam op_t OP_SRL   = 6'd34;
    localparam op_t OP_SRA   = 6'd35;
    localparam op_t OP_OR    = 6'd36;
    localparam op_t OP_AND   = 6'd37;

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder.
// Ports: req (N request bits) -> valid (any set), idx (lowest set bit).
module rs_select #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops ALU/LSB CDBs,
// issues one ready op per cycle. Ports: clk, rst, rdy, roll, DSP_* in,
// ALU_*/LSB_* CDB in, RS_full out, RS_flag/op/Vj/Vk/idx/imm/PC issue out.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_INDEX_RANGE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             roll,
    input  logic             DSP_flag,
    input  logic [5:0]       DSP_op,
    input  logic             DSP_Qj_busy,
    input  logic [ROB_W-1:0] DSP_Qj,
    input  logic [31:0]      DSP_Vj,
    input  logic             DSP_Qk_busy,
    input  logic [ROB_W-1:0] DSP_Qk,
    input  logic [31:0]      DSP_Vk,
    input  logic [ROB_W-1:0] DSP_idx,
    input  logic [31:0]      DSP_imm,
    input  logic [31:0]      DSP_PC,
    input  logic             ALU_flag,
    input  logic [ROB_W-1:0] ALU_ROB_idx,
    input  logic [31:0]      ALU_val,
    input  logic             LSB_flag,
    input  logic [ROB_W-1:0] LSB_ROB_idx,
    input  logic [31:0]      LSB_val,
    output logic             RS_full,
    output logic             RS_flag,
    output logic [5:0]       RS_op,
    output logic [31:0]      RS_Vj,
    output logic [31:0]      RS_Vk,
    output logic [ROB_W-1:0] RS_idx,
    output logic [31:0]      RS_imm,
    output logic [31:0]      RS_PC
);

    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy, qj_busy, qk_busy, ready;
    logic [5:0]         op_q  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        pc_q  [RS_SIZE];
    logic [ROB_W-1:0]   qj_q  [RS_SIZE];
    logic [ROB_W-1:0]   qk_q  [RS_SIZE];
    logic [ROB_W-1:0]   idx_q [RS_SIZE];

    logic [RS_SIZE-1:0] wake_j, wake_k;
    logic [31:0]        wj_val [RS_SIZE];
    logic [31:0]        wk_val [RS_SIZE];

    logic               free_vld, iss_vld;
    logic [IW-1:0]      free_idx, iss_idx;
    logic               dj_busy, dk_busy;
    logic [31:0]        dj_val, dk_val;

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_wake
        logic ja, jl, ka, kl;
        assign ja = ALU_flag && (qj_q[g] == ALU_ROB_idx);
        assign jl = LSB_flag && (qj_q[g] == LSB_ROB_idx);
        assign ka = ALU_flag && (qk_q[g] == ALU_ROB_idx);
        assign kl = LSB_flag && (qk_q[g] == LSB_ROB_idx);
        assign wake_j[g] = busy[g] && qj_busy[g] && (ja || jl);
        assign wake_k[g] = busy[g] && qk_busy[g] && (ka || kl);
        assign wj_val[g] = ja ? ALU_val : LSB_val;
        assign wk_val[g] = ka ? ALU_val : LSB_val;
    end

    // Readiness uses stored state only; a wake shows up one edge later.
    assign ready   = busy & ~qj_busy & ~qk_busy;
    assign RS_full = ~free_vld;

    rs_select #(.N(RS_SIZE), .IW(IW)) u_free_sel (
        .req   (~busy),
        .valid (free_vld),
        .idx   (free_idx)
    );

    rs_select #(.N(RS_SIZE), .IW(IW)) u_ready_sel (
        .req   (ready),
        .valid (iss_vld),
        .idx   (iss_idx)
    );

    // Operand capture straight off a CDB in the dispatch cycle.
    always_comb begin
        dj_busy = DSP_Qj_busy;
        dj_val  = DSP_Vj;
        dk_busy = DSP_Qk_busy;
        dk_val  = DSP_Vk;
        if (DSP_Qj_busy) begin
            if (ALU_flag && DSP_Qj == ALU_ROB_idx) begin
                dj_busy = FALSE;
                dj_val  = ALU_val;
            end else if (LSB_flag && DSP_Qj == LSB_ROB_idx) begin
                dj_busy = FALSE;
                dj_val  = LSB_val;
            end
        end
        if (DSP_Qk_busy) begin
            if (ALU_flag && DSP_Qk == ALU_ROB_idx) begin
                dk_busy = FALSE;
                dk_val  = ALU_val;
            end else if (LSB_flag && DSP_Qk == LSB_ROB_idx) begin
                dk_busy = FALSE;
                dk_val  = LSB_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            qj_busy <= '0;
            qk_busy <= '0;
            RS_flag <= FALSE;
            RS_op   <= '0;
            RS_Vj   <= '0;
            RS_Vk   <= '0;
            RS_idx  <= '0;
            RS_imm  <= '0;
            RS_PC   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                idx_q[i] <= '0;
            end
        end else if (rdy) begin
            if (roll) begin
                busy    <= '0;
                RS_flag <= FALSE;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (wake_j[i]) begin
                        qj_busy[i] <= FALSE;
                        vj_q[i]    <= wj_val[i];
                    end
                    if (wake_k[i]) begin
                        qk_busy[i] <= FALSE;
                        vk_q[i]    <= wk_val[i];
                    end
                end
                if (iss_vld) begin
                    RS_flag       <= TRUE;
                    RS_op         <= op_q[iss_idx];
                    RS_Vj         <= vj_q[iss_idx];
                    RS_Vk         <= vk_q[iss_idx];
                    RS_idx        <= idx_q[iss_idx];
                    RS_imm        <= imm_q[iss_idx];
                    RS_PC         <= pc_q[iss_idx];
                    busy[iss_idx] <= FALSE;
                end else begin
                    RS_flag <= FALSE;
                end
                // Free entry is chosen from pre-edge busy bits, so it never
                // collides with the entry being issued or woken.
                if (DSP_flag && free_vld) begin
                    busy[free_idx]    <= TRUE;
                    op_q[free_idx]    <= DSP_op;
                    qj_busy[free_idx] <= dj_busy;
                    qj_q[free_idx]    <= DSP_Qj;
                    vj_q[free_idx]    <= dj_val;
                    qk_busy[free_idx] <= dk_busy;
                    qk_q[free_idx]    <= DSP_Qk;
                    vk_q[free_idx]    <= dk_val;
                    idx_q[free_idx]   <= DSP_idx;
                    imm_q[free_idx]   <= DSP_imm;
                    pc_q[free_idx]    <= DSP_PC;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed dispatch/wakeup/bypass/full/roll/reset.
// Expected issues are queued by stimulus and checked by a negedge monitor.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk = 0;
    logic        rst, rdy, roll;
    logic        DSP_flag, DSP_Qj_busy, DSP_Qk_busy;
    logic [5:0]  DSP_op;
    logic [3:0]  DSP_Qj, DSP_Qk, DSP_idx;
    logic [31:0] DSP_Vj, DSP_Vk, DSP_imm, DSP_PC;
    logic        ALU_flag, LSB_flag;
    logic [3:0]  ALU_ROB_idx, LSB_ROB_idx;
    logic [31:0] ALU_val, LSB_val;
    logic        RS_full, RS_flag;
    logic [5:0]  RS_op;
    logic [31:0] RS_Vj, RS_Vk, RS_imm, RS_PC;
    logic [3:0]  RS_idx;

    alu_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .roll(roll),
        .DSP_flag(DSP_flag), .DSP_op(DSP_op),
        .DSP_Qj_busy(DSP_Qj_busy), .DSP_Qj(DSP_Qj), .DSP_Vj(DSP_Vj),
        .DSP_Qk_busy(DSP_Qk_busy), .DSP_Qk(DSP_Qk), .DSP_Vk(DSP_Vk),
        .DSP_idx(DSP_idx), .DSP_imm(DSP_imm), .DSP_PC(DSP_PC),
        .ALU_flag(ALU_flag), .ALU_ROB_idx(ALU_ROB_idx), .ALU_val(ALU_val),
        .LSB_flag(LSB_flag), .LSB_ROB_idx(LSB_ROB_idx), .LSB_val(LSB_val),
        .RS_full(RS_full), .RS_flag(RS_flag), .RS_op(RS_op),
        .RS_Vj(RS_Vj), .RS_Vk(RS_Vk), .RS_idx(RS_idx),
        .RS_imm(RS_imm), .RS_PC(RS_PC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj, vk;
        logic [3:0]  idx;
        logic [31:0] imm, pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_err = 0;

    always @(negedge clk) begin
        if (!rst && rdy && RS_flag) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue: got op=%0d idx=%0d, required no issue",
                         RS_op, RS_idx);
            end else begin
                m_e = exp_q.pop_front();
                if (RS_op !== m_e.op || RS_Vj !== m_e.vj || RS_Vk !== m_e.vk ||
                    RS_idx !== m_e.idx || RS_imm !== m_e.imm || RS_PC !== m_e.pc) begin
                    n_err++;
                    $display("FAIL issue_fields: got op=%0d vj=%h vk=%h idx=%0d imm=%h pc=%h, required op=%0d vj=%h vk=%h idx=%0d imm=%h pc=%h",
                             RS_op, RS_Vj, RS_Vk, RS_idx, RS_imm, RS_PC,
                             m_e.op, m_e.vj, m_e.vk, m_e.idx, m_e.imm, m_e.pc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [3:0] idx, input logic [31:0] imm, input logic [31:0] pc);
        exp_t e;
        e.op = op; e.vj = vj; e.vk = vk; e.idx = idx; e.imm = imm; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic set_dsp(input logic [5:0] op,
                           input logic qjb, input logic [3:0] qj, input logic [31:0] vj,
                           input logic qkb, input logic [3:0] qk, input logic [31:0] vk,
                           input logic [3:0] idx, input logic [31:0] imm, input logic [31:0] pc);
        DSP_flag = 1; DSP_op = op;
        DSP_Qj_busy = qjb; DSP_Qj = qj; DSP_Vj = vj;
        DSP_Qk_busy = qkb; DSP_Qk = qk; DSP_Vk = vk;
        DSP_idx = idx; DSP_imm = imm; DSP_PC = pc;
    endtask

    task automatic set_alu(input logic [3:0] t, input logic [31:0] v);
        ALU_flag = 1; ALU_ROB_idx = t; ALU_val = v;
    endtask

    task automatic set_lsb(input logic [3:0] t, input logic [31:0] v);
        LSB_flag = 1; LSB_ROB_idx = t; LSB_val = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        DSP_flag = 0; ALU_flag = 0; LSB_flag = 0; roll = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flag"}, RS_flag, 0);
        chk({tag, "_full"}, RS_full, 0);
        chk({tag, "_op"},   RS_op,   0);
        chk({tag, "_vj"},   RS_Vj,   0);
        chk({tag, "_vk"},   RS_Vk,   0);
        chk({tag, "_idx"},  RS_idx,  0);
        chk({tag, "_imm"},  RS_imm,  0);
        chk({tag, "_pc"},   RS_PC,   0);
    endtask

    initial begin
        rst = 1; rdy = 1; roll = 0;
        DSP_flag = 0; DSP_op = 0; DSP_Qj_busy = 0; DSP_Qj = 0; DSP_Vj = 0;
        DSP_Qk_busy = 0; DSP_Qk = 0; DSP_Vk = 0; DSP_idx = 0; DSP_imm = 0; DSP_PC = 0;
        ALU_flag = 0; ALU_ROB_idx = 0; ALU_val = 0;
        LSB_flag = 0; LSB_ROB_idx = 0; LSB_val = 0;
        #3;
        chk_zero("reset");
        @(negedge clk);
        rst = 0;
        tick();

        // Ready dispatch: issue one edge after capture, single-cycle pulse.
        set_dsp(OP_ADD, 0, 0, 5, 0, 0, 7, 3, 0, 32'h1000);
        push(OP_ADD, 5, 7, 3, 0, 32'h1000);
        tick();
        chk("lat_e0_flag", RS_flag, 0);
        tick();
        chk("lat_e1_flag", RS_flag, 1);
        chk("lat_e1_idx", RS_idx, 3);
        tick();
        chk("pulse_end", RS_flag, 0);

        // Wakeup from ALU bus.
        set_dsp(OP_ADDI, 1, 2, 32'hDEAD, 0, 0, 0, 4, 32'h20, 32'h1004);
        tick();
        tick();
        chk("wait_no_issue", RS_flag, 0);
        set_alu(2, 32'h10);
        push(OP_ADDI, 32'h10, 0, 4, 32'h20, 32'h1004);
        tick();
        chk("wake_e0_flag", RS_flag, 0);
        tick();
        chk("wake_vj", RS_Vj, 32'h10);
        tick();

        // Dispatch bypass from LSB bus.
        set_dsp(OP_SUB, 0, 0, 3, 1, 6, 0, 5, 0, 32'h1008);
        set_lsb(6, 32'hFFFF_FFFF);
        push(OP_SUB, 3, 32'hFFFF_FFFF, 5, 0, 32'h1008);
        tick();
        tick();
        chk("bypass_vk", RS_Vk, 32'hFFFF_FFFF);
        tick();

        // Both buses carry the tag: ALU value wins.
        set_dsp(OP_OR, 1, 7, 0, 1, 7, 0, 6, 0, 32'h100C);
        set_alu(7, 32'hA);
        set_lsb(7, 32'hB);
        push(OP_OR, 32'hA, 32'hA, 6, 0, 32'h100C);
        tick();
        tick();
        tick();

        // Back-to-back ready dispatches reuse freed entries.
        set_dsp(OP_SLTU, 0, 0, 1, 0, 0, 2, 7, 0, 32'h1100);
        push(OP_SLTU, 1, 2, 7, 0, 32'h1100);
        tick();
        set_dsp(OP_SRA, 0, 0, 3, 0, 0, 4, 8, 0, 32'h1104);
        push(OP_SRA, 3, 4, 8, 0, 32'h1104);
        tick();
        set_dsp(OP_SRL, 0, 0, 5, 0, 0, 6, 9, 0, 32'h1108);
        push(OP_SRL, 5, 6, 9, 0, 32'h1108);
        tick();
        tick();
        tick();
        chk("b2b_drained", RS_flag, 0);

        // Fill every entry with a pending op (entry i waits on tag i).
        for (int i = 0; i < 16; i++) begin
            set_dsp(OP_XOR, 1, 4'(i), 0, 0, 0, 32'(i * 3), 4'(i), 0, 32'h2000 + 32'(4 * i));
            tick();
        end
        chk("full_set", RS_full, 1);
        set_dsp(OP_AND, 0, 0, 1, 0, 0, 2, 15, 0, 32'h3000);
        tick();
        chk("full_drop", RS_full, 1);
        set_alu(5, 32'h55);
        set_lsb(1, 32'h11);
        push(OP_XOR, 32'h11, 3, 1, 0, 32'h2004);
        push(OP_XOR, 32'h55, 15, 5, 0, 32'h2014);
        tick();
        chk("order_e0_flag", RS_flag, 0);
        tick();
        chk("order_first", RS_idx, 1);
        chk("full_clear", RS_full, 0);
        tick();
        chk("order_second", RS_idx, 5);
        chk("order_second_flag", RS_flag, 1);

        // Roll beats a same-edge wakeup and empties the station.
        roll = 1;
        set_alu(0, 32'h1);
        tick();
        chk("roll_flag", RS_flag, 0);
        chk("roll_full", RS_full, 0);
        for (int t = 0; t < 16; t += 2) begin
            set_alu(4'(t), 32'h77);
            set_lsb(4'(t + 1), 32'h88);
            tick();
        end
        chk("roll_no_issue", RS_flag, 0);

        // rdy low freezes everything.
        set_dsp(OP_SLT, 0, 0, 9, 0, 0, 8, 10, 0, 32'h4000);
        push(OP_SLT, 9, 8, 10, 0, 32'h4000);
        tick();
        rdy = 0;
        tick();
        chk("rdy_hold1", RS_flag, 0);
        tick();
        chk("rdy_hold2", RS_flag, 0);
        rdy = 1;
        tick();
        chk("rdy_resume_flag", RS_flag, 1);
        chk("rdy_resume_idx", RS_idx, 10);
        tick();

        // Asynchronous reset mid-run drops the pending op.
        set_dsp(OP_AND, 1, 12, 0, 0, 0, 0, 11, 0, 32'h5000);
        tick();
        set_dsp(OP_SLL, 0, 0, 1, 0, 0, 4, 12, 0, 32'h5004);
        push(OP_SLL, 1, 4, 12, 0, 32'h5004);
        tick();
        tick();
        chk("pre_rst_flag", RS_flag, 1);
        @(negedge clk);
        #1;
        rst = 1;
        #1;
        chk_zero("midrst");
        rst = 0;
        set_alu(12, 32'h99);
        tick();
        tick();
        tick();

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding issues, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
